const_div_seq: RTL and testbench

- Parametrised, iterative unsigned divider by a compile-time constant DIVISOR.
- Successor to the fixed-width, fixed-radix combinational remainder/quotient digit slices used for divide-by-5 on 64 bits.
- Retires DIGIT dividend bits per clock through a single shared digit-recurrence stage.
- Wrapped in valid/ready handshakes on input and output so it can sit in a streaming datapath.

---
 rtl/const_div_seq.sv | 118 +++++++++++
 tb/tb_const_div_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/const_div_seq.sv
// Iterative unsigned divide by a constant DIVISOR, retiring DIGIT dividend bits
// per clock through one shared digit stage, with valid/ready on both sides.
module const_div_seq #(
    parameter int WIDTH   = 64,
    parameter int DIVISOR = 5,
    parameter int DIGIT   = 3,
    localparam int REM_W  = $clog2(DIVISOR),
    localparam int ITER   = (WIDTH + DIGIT - 1) / DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [REM_W-1:0] out_rem,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a dividend, in_ready high
    // RUN   | one radix-2^DIGIT digit retired per clock
    // DONE  | result presented, held until out_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int SW    = ITER * DIGIT;
    localparam int TW    = REM_W + DIGIT;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    generate
        if (DIVISOR < 2 || DIVISOR > 65536) begin : g_bad_divisor
            $error("const_div_seq: DIVISOR must lie in 2..65536");
        end
        if (DIGIT < 1 || DIGIT > 8) begin : g_bad_digit
            $error("const_div_seq: DIGIT must lie in 1..8");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    div_q, div_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [TW-1:0]    t;
    logic [DIGIT-1:0] qd;
    logic [REM_W-1:0] rd;

    // Constant divide of a short word; rem_q < DIVISOR keeps the quotient digit within DIGIT bits.
    always_comb begin
        t  = {rem_q, div_q[SW-1 -: DIGIT]};
        qd = DIGIT'(t / TW'(DIVISOR));
        rd = REM_W'(t % TW'(DIVISOR));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d   = SW'(in_data);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                div_d  = div_q << DIGIT;
                // Padding digits at the top always yield zero, so a WIDTH-bit register suffices.
                quot_d = WIDTH'({quot_q, qd});
                rem_d  = rd;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_quot  = quot_q;
    assign out_rem   = rem_q;

endmodule

// File: tb/tb_const_div_seq.sv
// Bench for const_div_seq: default instance plus two parameter variants,
// checked every cycle against an arithmetic reference of the handshake and result.
module tb_const_div_seq;

    localparam int N_SWEEP = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid  [3];
    logic [63:0] in_data   [3];
    logic        out_ready [3];
    logic        o_ready   [3];
    logic        o_valid   [3];
    logic        o_busy    [3];
    logic [63:0] o_quot    [3];
    logic [15:0] o_rem     [3];

    logic [63:0] a_q;
    logic [2:0]  a_r;
    logic [31:0] b_q;
    logic [2:0]  b_r;
    logic [16:0] c_q;
    logic [1:0]  c_r;

    int tests = 0;
    int fails = 0;

    const_div_seq dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(o_ready[0]), .in_data(in_data[0]),
        .out_valid(o_valid[0]), .out_ready(out_ready[0]),
        .out_quot(a_q), .out_rem(a_r), .busy(o_busy[0])
    );

    const_div_seq #(.WIDTH(32), .DIVISOR(7), .DIGIT(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(o_ready[1]), .in_data(in_data[1][31:0]),
        .out_valid(o_valid[1]), .out_ready(out_ready[1]),
        .out_quot(b_q), .out_rem(b_r), .busy(o_busy[1])
    );

    const_div_seq #(.WIDTH(17), .DIVISOR(3), .DIGIT(5)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(o_ready[2]), .in_data(in_data[2][16:0]),
        .out_valid(o_valid[2]), .out_ready(out_ready[2]),
        .out_quot(c_q), .out_rem(c_r), .busy(o_busy[2])
    );

    assign o_quot[0] = a_q;
    assign o_quot[1] = 64'(b_q);
    assign o_quot[2] = 64'(c_q);
    assign o_rem[0]  = 16'(a_r);
    assign o_rem[1]  = 16'(b_r);
    assign o_rem[2]  = 16'(c_r);

    function automatic int iter_of(input int k);
        return (k == 0) ? 22 : (k == 1) ? 8 : 4;
    endfunction

    function automatic int div_of(input int k);
        return (k == 0) ? 5 : (k == 1) ? 7 : 3;
    endfunction

    function automatic logic [63:0] masked(input int k, input logic [63:0] d);
        int w;
        w = (k == 0) ? 64 : (k == 1) ? 32 : 17;
        return (w == 64) ? d : (d & ((64'd1 << w) - 64'd1));
    endfunction

    task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 50)
                $display("FAIL dut%0d %s: got %0d, expected %0d", k, nm, act, exp);
        end
    endtask

    // Reference: a dividend accepted when idle yields floor/mod exactly ITER edges later,
    // held until taken; everything else offered meanwhile is ignored.
    bit          pend [3];
    int          n    [3];
    logic [63:0] eq   [3];
    logic [15:0] er   [3];
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                pend[k] <= 1'b0;
            end else if (pend[k]) begin
                if (n[k] >= iter_of(k)) begin
                    if (out_ready[k]) pend[k] <= 1'b0;
                end else begin
                    n[k] <= n[k] + 1;
                end
            end else if (in_valid[k]) begin
                pend[k] <= 1'b1;
                n[k]    <= 0;
                eq[k]   <= masked(k, in_data[k]) / 64'(div_of(k));
                er[k]   <= 16'(masked(k, in_data[k]) % 64'(div_of(k)));
            end
        end
        if (rst) model_on <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 3; k++) begin
                bit v;
                v = pend[k] && (n[k] >= iter_of(k));
                chk(k, "in_ready",  64'(o_ready[k]), 64'(!pend[k]));
                chk(k, "busy",      64'(o_busy[k]),  64'(pend[k]));
                chk(k, "out_valid", 64'(o_valid[k]), 64'(v));
                if (v) begin
                    chk(k, "out_quot", o_quot[k], eq[k]);
                    chk(k, "out_rem",  64'(o_rem[k]), 64'(er[k]));
                end
            end
        end
    end

    task automatic xfer(input int k, input logic [63:0] data, output int lat,
                        output logic [63:0] q, output logic [15:0] r, output bit ok);
        int w;
        w   = 0;
        lat = 0;
        ok  = 1'b0;
        q   = '0;
        r   = '0;
        while (!o_ready[k] && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        in_data[k]  = data;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        while (!o_valid[k] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (o_valid[k]) begin
            ok = 1'b1;
            q  = o_quot[k];
            r  = o_rem[k];
        end
    endtask

    task automatic take_out(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
    endtask

    task automatic run_vec(input logic [63:0] data, input logic [63:0] q_lit, input logic [15:0] r_lit);
        int lat; logic [63:0] q; logic [15:0] r; bit ok;
        xfer(0, data, lat, q, r, ok);
        chk(0, "result seen", 64'(ok), 64'd1);
        chk(0, "latency", 64'(lat), 64'd22);
        chk(0, "quot literal", q, q_lit);
        chk(0, "rem literal", 64'(r), 64'(r_lit));
        take_out(0);
        chk(0, "idle after take", 64'(o_ready[0]), 64'd1);
    endtask

    task automatic sweep(input int k);
        int lat; logic [63:0] q; logic [15:0] r; bit ok; logic [63:0] d;
        for (int i = 0; i < N_SWEEP; i++) begin
            d = (i == 0) ? 64'd0 : (i == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom(), $urandom()};
            xfer(k, d, lat, q, r, ok);
            chk(k, "result seen", 64'(ok), 64'd1);
            chk(k, "latency", 64'(lat), 64'(iter_of(k)));
            if (i == 0) begin
                chk(k, "quot of 0", q, 64'd0);
                chk(k, "rem of 0", 64'(r), 64'd0);
            end
            if (i == 1) begin
                chk(k, "quot of ones", q, (k == 1) ? 64'd613566756 : 64'd43690);
                chk(k, "rem of ones", 64'(r), (k == 1) ? 64'd3 : 64'd1);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            take_out(k);
        end
    endtask

    initial begin
        int lat; logic [63:0] q; logic [15:0] r; bit ok;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk(0, "reset in_ready",  64'(o_ready[0]), 64'd1);
        chk(0, "reset out_valid", 64'(o_valid[0]), 64'd0);
        chk(0, "reset busy",      64'(o_busy[0]),  64'd0);
        chk(0, "reset quot",      o_quot[0],       64'd0);
        chk(0, "reset rem",       64'(o_rem[0]),   64'd0);

        run_vec(64'd0, 64'd0, 16'd0);
        run_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'd3689348814741910323, 16'd0);
        run_vec(64'd7, 64'd1, 16'd2);
        run_vec(64'hFFFF_FFFF_FFFF_FFFE, 64'd3689348814741910322, 16'd4);

        // Backpressure with a stray dividend offered while the result waits.
        xfer(0, 64'd100, lat, q, r, ok);
        chk(0, "bp result seen", 64'(ok), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_data[0]  = 64'd999;
                in_valid[0] = 1'b1;
            end
            @(posedge clk); #1;
            in_valid[0] = 1'b0;
            chk(0, "bp out_valid", 64'(o_valid[0]), 64'd1);
            chk(0, "bp in_ready",  64'(o_ready[0]), 64'd0);
            chk(0, "bp quot",      o_quot[0],       64'd20);
            chk(0, "bp rem",       64'(o_rem[0]),   64'd0);
        end
        take_out(0);
        chk(0, "bp idle", 64'(o_ready[0]), 64'd1);
        chk(0, "bp busy", 64'(o_busy[0]),  64'd0);

        // Reset at iteration 10 of a division.
        in_data[0]  = 64'd5555;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk(0, "midrst in_ready",  64'(o_ready[0]), 64'd1);
        chk(0, "midrst out_valid", 64'(o_valid[0]), 64'd0);
        chk(0, "midrst busy",      64'(o_busy[0]),  64'd0);
        chk(0, "midrst quot",      o_quot[0],       64'd0);
        run_vec(64'd12345, 64'd2469, 16'd0);

        fork
            sweep(1);
            sweep(2);
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
